// File: rtl/poly_mm_wb_if.sv
// poly_mm_wb_if: multiplier-result input and RAM write-port signals of poly_mm_wb.
// slave is the writeback block's view; master is the view of its surroundings.
interface poly_mm_wb_if #(
  parameter int unsigned W      = 24,
  parameter int unsigned N_COEF = 256
);
  localparam int unsigned AW = $clog2(N_COEF);

  logic          in_valid;
  logic [W-1:0]  in_share1;
  logic [W-1:0]  in_share2;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [W-1:0]  out_share1;
  logic [W-1:0]  out_share2;

  modport master (
    output in_valid, in_share1, in_share2, out_ready,
    input  out_valid, out_addr, out_share1, out_share2
  );

  modport slave (
    input  in_valid, in_share1, in_share2, out_ready,
    output out_valid, out_addr, out_share1, out_share2
  );
endinterface

// File: rtl/poly_mm_wb.sv
// poly_mm_wb: tags Barrett multiplier results with a coefficient index and buffers them for RAM.
// Macro POLY_WB_UNMASK_EN stores share1^share2 instead of the shares and range-checks it against wb_q.
module poly_mm_wb #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned N_COEF   = 256,
  parameter int unsigned W        = 24,
  parameter int unsigned STALL_TH = 4
) (
  input  logic         poly_wb_clk,
  input  logic         poly_wb_rst,
  input  logic         wb_start,
  input  logic [W-1:0] wb_q,
  output logic         wb_stall,
  output logic         wb_busy,
  output logic         wb_done,
  output logic         err_overflow,
  output logic         err_unexp,
  output logic         err_range,
  poly_mm_wb_if.slave  bus
);
  localparam int unsigned AW = $clog2(N_COEF);
  localparam int unsigned IW = AW + 1;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = AW + 2 * W;
  localparam logic [IW-1:0] NCoef   = IW'(N_COEF);
  localparam logic [CW-1:0] Depth   = CW'(DEPTH);
  localparam logic [CW-1:0] StallTh = CW'(STALL_TH);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;
  state_e state_q, state_d;

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] in_idx_q, in_idx_d, out_cnt_q, out_cnt_d;
  logic          stall_q, stall_d, ovf_q, ovf_d, unexp_q, unexp_d, range_q, range_d;
  logic          head_valid, full, push_req, push, pop, range_hit;
  logic [W-1:0]  wr_s1, wr_s2;
  logic [EW-1:0] head;

`ifdef POLY_WB_UNMASK_EN
  logic [W-1:0] unmasked;
  assign unmasked  = bus.in_share1 ^ bus.in_share2;
  assign wr_s1     = unmasked;
  assign wr_s2     = '0;
  assign range_hit = unmasked >= wb_q;
`else
  logic unused_wb_q;
  assign unused_wb_q = |wb_q;
  assign wr_s1       = bus.in_share1;
  assign wr_s2       = bus.in_share2;
  assign range_hit   = 1'b0;
`endif

  assign head_valid = count_q != '0;
  assign full       = count_q == Depth;
  assign pop        = head_valid && bus.out_ready;
  assign push_req   = bus.in_valid && (state_q == StRun);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push       = push_req && (!full || pop);

  always_comb begin
    state_d   = state_q;
    in_idx_d  = in_idx_q;
    out_cnt_d = pop ? out_cnt_q + IW'(1) : out_cnt_q;
    ovf_d     = ovf_q;
    unexp_d   = unexp_q;
    range_d   = range_q;
    count_d   = count_q + CW'(push) - CW'(pop);
    wptr_d    = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d    = pop ? rptr_q + PW'(1) : rptr_q;
    case (state_q)
      StIdle: begin
        if (wb_start) begin
          state_d   = StRun;
          in_idx_d  = '0;
          out_cnt_d = '0;
          ovf_d     = 1'b0;
          unexp_d   = 1'b0;
          range_d   = 1'b0;
        end
      end
      StRun: begin
        // Index advances even on a dropped push so later addresses stay aligned.
        if (bus.in_valid) begin
          in_idx_d = in_idx_q + IW'(1);
          if (in_idx_d == NCoef) state_d = StDrain;
        end
      end
      StDrain: if (out_cnt_d == NCoef && count_d == '0) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (bus.in_valid && state_q != StRun) unexp_d = 1'b1;
    if (push_req && full && !pop)         ovf_d   = 1'b1;
    if (push_req && range_hit)            range_d = 1'b1;
    stall_d = (Depth - count_d) <= StallTh;
  end

  always_ff @(posedge poly_wb_clk) begin
    if (poly_wb_rst) begin
      state_q   <= StIdle;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      in_idx_q  <= '0;
      out_cnt_q <= '0;
      stall_q   <= 1'b0;
      ovf_q     <= 1'b0;
      unexp_q   <= 1'b0;
      range_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      in_idx_q  <= in_idx_d;
      out_cnt_q <= out_cnt_d;
      stall_q   <= stall_d;
      ovf_q     <= ovf_d;
      unexp_q   <= unexp_d;
      range_q   <= range_d;
    end
  end

  always_ff @(posedge poly_wb_clk) begin
    if (push) mem_q[wptr_q] <= {in_idx_q[AW-1:0], wr_s1, wr_s2};
  end

  assign head           = mem_q[rptr_q];
  assign bus.out_valid  = head_valid;
  assign bus.out_addr   = head_valid ? head[EW-1 -: AW] : '0;
  assign bus.out_share1 = head_valid ? head[2*W-1 -: W] : '0;
  assign bus.out_share2 = head_valid ? head[W-1:0] : '0;
  assign wb_stall       = stall_q;
  assign wb_busy        = state_q != StIdle;
  assign wb_done        = state_q == StDone;
  assign err_overflow   = ovf_q;
  assign err_unexp      = unexp_q;
  assign err_range      = range_q;
endmodule

// File: tb/tb_poly_mm_wb.sv
// tb_poly_mm_wb: drives poly_mm_wb with directed and $urandom traffic, checked against a
// queue-based reference model of the writeback pass.
module tb_poly_mm_wb;
  localparam int unsigned DEPTH    = 8;
  localparam int unsigned N_COEF   = 256;
  localparam int unsigned W        = 24;
  localparam int unsigned STALL_TH = 4;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] q;
  logic         stall, busy, done, ovf, unexp, rng;

  poly_mm_wb_if #(.W(W), .N_COEF(N_COEF)) bus ();

  poly_mm_wb #(.DEPTH(DEPTH), .N_COEF(N_COEF), .W(W), .STALL_TH(STALL_TH)) dut (
    .poly_wb_clk (clk),
    .poly_wb_rst (rst),
    .wb_start    (start),
    .wb_q        (q),
    .wb_stall    (stall),
    .wb_busy     (busy),
    .wb_done     (done),
    .err_overflow(ovf),
    .err_unexp   (unexp),
    .err_range   (rng),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]   a;
    logic [W-1:0] s1;
    logic [W-1:0] s2;
  } ent_t;

  // Reference model: pass mode 0 idle, 1 accepting, 2 draining, 3 finished.
  ent_t mq[$];
  int   m_state, m_in, m_out;
  bit   m_ovf, m_unexp, m_rng, m_stall, m_done;
  int   tests_run = 0, tests_failed = 0;

  task automatic model_reset();
    mq.delete();
    m_state = 0; m_in = 0; m_out = 0;
    m_ovf = 0; m_unexp = 0; m_rng = 0; m_stall = 0; m_done = 0;
  endtask

  task automatic step(input bit st, input bit v, input logic [W-1:0] s1, input logic [W-1:0] s2,
                      input bit rdy);
    bit   pop, full;
    int   nxt;
    ent_t e;
    start = st; bus.in_valid = v; bus.in_share1 = s1; bus.in_share2 = s2; bus.out_ready = rdy;
    @(posedge clk);
    full = (mq.size() == DEPTH);
    pop  = rdy && (mq.size() > 0);
    nxt  = m_state;
    if (pop) begin
      void'(mq.pop_front());
      m_out++;
    end
    case (m_state)
      0: if (st) begin
        nxt = 1; m_in = 0; m_out = 0; m_ovf = 0; m_unexp = 0; m_rng = 0;
      end
      1: if (v) begin
        e.a = m_in[7:0];
`ifdef POLY_WB_UNMASK_EN
        e.s1 = s1 ^ s2; e.s2 = '0;
        if ((s1 ^ s2) >= q) m_rng = 1;
`else
        e.s1 = s1; e.s2 = s2;
`endif
        if (full && !pop) m_ovf = 1;
        else mq.push_back(e);
        m_in++;
        if (m_in == N_COEF) nxt = 2;
      end
      2: if (m_out == N_COEF && mq.size() == 0) nxt = 3;
      default: nxt = 0;
    endcase
    if (v && m_state != 1) m_unexp = 1;
    m_state = nxt;
    m_done  = (nxt == 3);
    m_stall = (DEPTH - mq.size()) <= STALL_TH;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1; start = 0; bus.in_valid = 0; bus.out_ready = 0;
    bus.in_share1 = '0; bus.in_share2 = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    tests_run++;
    if ({bus.out_valid, bus.out_addr, bus.out_share1, bus.out_share2} !== '0) begin
      tests_failed++;
      $display("FAIL reset_bus: got %0h want 0",
               {bus.out_valid, bus.out_addr, bus.out_share1, bus.out_share2});
    end
    tests_run++;
    if ({stall, busy, done, ovf, unexp, rng} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_status: got %b want 000000", {stall, busy, done, ovf, unexp, rng});
    end
  endtask

  // mode 0: fixed share pattern, RAM always ready; mode 1: random shares and RAM readiness.
  // The enable is delayed four cycles, like the multiplier it models.
  task automatic test_pass(input int mode);
    logic [3:0]   pipe = '0;
    int           en_cnt = 0, push_cnt = 0, done_cnt = 0, cyc = 0;
    bit           en, v, rdy;
    logic [W-1:0] s1, s2;
    step(1, 0, '0, '0, 1);
    while ((en_cnt < N_COEF || pipe != 0 || m_state != 0) && cyc < 6000) begin
      en   = !stall && (en_cnt < N_COEF);
      v    = pipe[3];
      pipe = {pipe[2:0], en};
      if (en) en_cnt++;
      if (mode == 0) begin
        s1 = W'(push_cnt) ^ 24'hACE123; s2 = 24'hACE123; rdy = 1;
      end else begin
        s1 = W'($urandom()); s2 = W'($urandom()); rdy = ($urandom_range(0, 3) != 0);
      end
      step(0, v, s1, s2, rdy);
      if (v) push_cnt++;
      cyc++;
      tests_run++;
      if (bus.out_valid !== (mq.size() > 0)) begin
        tests_failed++;
        $display("FAIL pass%0d_valid cyc %0d: got %b want %b", mode, cyc, bus.out_valid,
                 mq.size() > 0);
      end
      if (mq.size() > 0) begin
        tests_run++;
        if ({bus.out_addr, bus.out_share1, bus.out_share2} !== mq[0]) begin
          tests_failed++;
          $display("FAIL pass%0d_head cyc %0d: got %0h want %0h", mode, cyc,
                   {bus.out_addr, bus.out_share1, bus.out_share2}, mq[0]);
        end
      end
      tests_run++;
      if ({stall, busy, done, ovf, unexp, rng} !==
          {m_stall, m_state != 0, m_done, m_ovf, m_unexp, m_rng}) begin
        tests_failed++;
        $display("FAIL pass%0d_status cyc %0d: got %b want %b", mode, cyc,
                 {stall, busy, done, ovf, unexp, rng},
                 {m_stall, m_state != 0, m_done, m_ovf, m_unexp, m_rng});
      end
      if (done) done_cnt++;
    end
    tests_run++;
    if (cyc >= 6000 || done_cnt != 1 || ovf !== 1'b0 || unexp !== 1'b0) begin
      tests_failed++;
      $display("FAIL pass%0d_end: cycles %0d done pulses %0d ovf %b unexp %b want <6000 1 0 0",
               mode, cyc, done_cnt, ovf, unexp);
    end
  endtask

  task automatic test_backpressure();
    step(1, 0, '0, '0, 0);
    for (int i = 0; i < 9; i++) begin
      step(0, 1, W'($urandom()), W'($urandom()), 0);
      if (i == 0) begin
        tests_run++;
        if (bus.out_valid !== 1'b1) begin
          tests_failed++;
          $display("FAIL bp_first_valid: got %b want 1", bus.out_valid);
        end
      end
      if (i == 2 || i == 3) begin
        tests_run++;
        if (stall !== (i == 3)) begin
          tests_failed++;
          $display("FAIL bp_stall_occ%0d: got %b want %b", i + 1, stall, i == 3);
        end
      end
      if (i == 7 || i == 8) begin
        tests_run++;
        if (ovf !== (i == 8)) begin
          tests_failed++;
          $display("FAIL bp_overflow_push%0d: got %b want %b", i + 1, ovf, i == 8);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, '0, '0, 0);
      tests_run++;
      if (bus.out_addr !== 8'd0 || {bus.out_addr, bus.out_share1, bus.out_share2} !== mq[0]) begin
        tests_failed++;
        $display("FAIL bp_hold: got %0h want %0h", {bus.out_addr, bus.out_share1, bus.out_share2},
                 mq[0]);
      end
    end
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (bus.out_valid !== 1'b1 || bus.out_addr !== 8'(i)) begin
        tests_failed++;
        $display("FAIL bp_drain: got valid %b addr %0d want 1 %0d", bus.out_valid, bus.out_addr, i);
      end
      step(0, 0, '0, '0, 1);
    end
    step(0, 1, 24'h123456, 24'h654321, 1);
    tests_run++;
    if (bus.out_valid !== 1'b1 || bus.out_addr !== 8'd9) begin
      tests_failed++;
      $display("FAIL bp_realign: got valid %b addr %0d want 1 9", bus.out_valid, bus.out_addr);
    end
    apply_reset();
  endtask

  task automatic test_full_push_pop();
    step(1, 0, '0, '0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, W'($urandom()), W'($urandom()), 0);
    step(0, 1, W'($urandom()), W'($urandom()), 1);
    tests_run++;
    if (ovf !== 1'b0 || stall !== 1'b1 || bus.out_addr !== 8'd1) begin
      tests_failed++;
      $display("FAIL fpp_accept: got ovf %b stall %b addr %0d want 0 1 1", ovf, stall,
               bus.out_addr);
    end
    for (int i = 1; i <= 8; i++) begin
      tests_run++;
      if (bus.out_valid !== 1'b1 || {bus.out_addr, bus.out_share1, bus.out_share2} !== mq[0]
          || bus.out_addr !== 8'(i)) begin
        tests_failed++;
        $display("FAIL fpp_drain: got valid %b addr %0d want 1 %0d", bus.out_valid,
                 bus.out_addr, i);
      end
      step(0, 0, '0, '0, 1);
    end
    tests_run++;
    if (bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL fpp_empty: got %b want 0", bus.out_valid);
    end
    apply_reset();
  endtask

  task automatic test_unexpected();
    step(0, 1, 24'h1, 24'h2, 1);
    tests_run++;
    if (unexp !== 1'b1 || bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL unexp_idle: got unexp %b valid %b want 1 0", unexp, bus.out_valid);
    end
    step(1, 0, '0, '0, 1);
    tests_run++;
    if (unexp !== 1'b0) begin
      tests_failed++;
      $display("FAIL unexp_clear1: got %b want 0", unexp);
    end
    for (int i = 0; i < N_COEF; i++) step(0, 1, W'($urandom()), W'($urandom()), 1);
    step(0, 1, 24'h7, 24'h8, 1);
    tests_run++;
    if (unexp !== 1'b1 || bus.out_valid !== 1'b0 || done !== 1'b1) begin
      tests_failed++;
      $display("FAIL unexp_drain: got unexp %b valid %b done %b want 1 0 1", unexp,
               bus.out_valid, done);
    end
    step(0, 0, '0, '0, 1);
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL unexp_idle_again: got busy %b done %b want 0 0", busy, done);
    end
    step(1, 0, '0, '0, 1);
    tests_run++;
    if (unexp !== 1'b0) begin
      tests_failed++;
      $display("FAIL unexp_clear2: got %b want 0", unexp);
    end
    apply_reset();
  endtask

  task automatic test_reset_midpass();
    step(1, 0, '0, '0, 1);
    for (int i = 0; i < 100; i++) step(0, 1, W'($urandom()), W'($urandom()), 1);
    apply_reset();
    tests_run++;
    if ({bus.out_valid, bus.out_addr, bus.out_share1, bus.out_share2, stall, busy, done, ovf,
         unexp, rng} !== '0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: got %0h want 0", {bus.out_valid, bus.out_addr,
               bus.out_share1, bus.out_share2, stall, busy, done, ovf, unexp, rng});
    end
    step(1, 0, '0, '0, 1);
    step(0, 1, 24'hABCDEF, 24'h13579B, 0);
    tests_run++;
    if ({bus.out_valid, bus.out_addr, bus.out_share1, bus.out_share2} !== {1'b1, mq[0]}
        || bus.out_addr !== 8'd0) begin
      tests_failed++;
      $display("FAIL midreset_restart: got %0h want %0h",
               {bus.out_valid, bus.out_addr, bus.out_share1, bus.out_share2}, {1'b1, mq[0]});
    end
    apply_reset();
  endtask

`ifdef POLY_WB_UNMASK_EN
  task automatic test_unmask();
    step(1, 0, '0, '0, 0);
    step(0, 1, 24'd8380417 ^ 24'h5A5A5A, 24'h5A5A5A, 0);
    tests_run++;
    if (rng !== 1'b1) begin
      tests_failed++;
      $display("FAIL unmask_range_hit: got %b want 1", rng);
    end
    apply_reset();
    step(1, 0, '0, '0, 0);
    step(0, 1, 24'd8380416 ^ 24'h0F0F0F, 24'h0F0F0F, 0);
    tests_run++;
    if (rng !== 1'b0 || bus.out_share1 !== 24'd8380416 || bus.out_share2 !== 24'd0) begin
      tests_failed++;
      $display("FAIL unmask_value: got rng %b s1 %0d s2 %0d want 0 8380416 0", rng,
               bus.out_share1, bus.out_share2);
    end
    apply_reset();
  endtask
`endif

  initial begin
    rst = 1; start = 0; q = 24'd8380417;
    bus.in_valid = 0; bus.in_share1 = '0; bus.in_share2 = '0; bus.out_ready = 0;
    model_reset();
    test_reset();
    test_pass(0);
    test_backpressure();
    test_full_push_pop();
    test_unexpected();
    test_reset_midpass();
`ifdef POLY_WB_UNMASK_EN
    test_unmask();
`endif
    // Back-to-back passes with no reset in between.
    test_pass(1);
    test_pass(1);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/poly_mm_wb.md
# poly_mm_wb

Writeback stage directly downstream of the Barrett pointwise multiplier. It captures the two 24-bit result shares on every multiplier valid pulse and tags each with a coefficient index. Results are buffered in a small FIFO and drained to polynomial RAM through a valid/ready port. The multiplier has no backpressure, so this block issues a stall credit signal that the feeding controller uses to gate the multiplier enable.

## Interface
Parameters:
- DEPTH, 8: FIFO entries; power of two, ≥ 8.
- N_COEF, 256: coefficients per polynomial pass.
- W, 24: share width.
- STALL_TH, 4: free-entry threshold for stall; equals the multiplier valid latency.

Ports:
- poly_wb_clk  in  1  clock; single clock domain.
- poly_wb_rst  in  1  reset; synchronous, active-high.
- wb_start  in  1  one-cycle pulse; begins a pass and clears error flags.
- in_valid  in  1  multiplier result valid.
- in_share1  in  W  masked share 1.
- in_share2  in  W  mask share 2.
- wb_q  in  W  modulus; used only with POLY_WB_UNMASK_EN.
- wb_stall  out  1  high when free entries ≤ STALL_TH.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  RAM accepts head.
- out_addr  out  clog2(N_COEF)  coefficient index of head.
- out_share1  out  W  head share 1.
- out_share2  out  W  head share 2.
- wb_busy  out  1  state ≠ IDLE.
- wb_done  out  1  one-cycle pulse; last coefficient written.
- err_overflow  out  1  sticky; push dropped because FIFO was full.
- err_unexp  out  1  sticky; in_valid arrived outside RUN.
- err_range  out  1  sticky; range-check failure (macro builds only).

## Operation
- Reset values: all outputs 0, state IDLE, FIFO empty, counters 0.
- The FIFO stores {index, share1, share2}. in_idx counts pushes and out_cnt counts pops; both are clog2(N_COEF)+1 bits.
- States:
  - IDLE: wb_start → RUN; clears in_idx, out_cnt and all err_*.
  - RUN: every in_valid pushes an entry tagged in_idx, then in_idx increments. When in_idx reaches N_COEF → DRAIN.
  - DRAIN: in_valid is dropped and sets err_unexp. When out_cnt = N_COEF and the FIFO is empty → DONE.
  - DONE: wb_done = 1 for one cycle → IDLE.
- A pop occurs when out_valid && out_ready; out_cnt increments on each pop. Popping continues in every state while the FIFO is non-empty.
- in_valid in IDLE is dropped and sets err_unexp.
- wb_start outside IDLE is ignored.
- Push when full with no simultaneous pop: entry is dropped, err_overflow is set, in_idx still increments so addresses stay aligned.
- Push when full with a simultaneous pop: push is accepted and occupancy stays at DEPTH.
- Push and pop on an empty FIFO: the new entry appears next cycle; it is not a fall-through.
- Share values pass through unchanged. The block never XORs share1 with share2 in default builds.
- wb_stall = (DEPTH − occupancy) ≤ STALL_TH. It is a registered version of next-state occupancy.
- Reset mid-pass: everything returns to reset values and FIFO contents are discarded.

## Timing
- Push at cycle t → out_valid = 1 at t+1 if the FIFO was empty.
- out_* is held stable while out_valid && !out_ready.
- wb_stall reflects occupancy after edge t at cycle t+1. With STALL_TH = 4, a controller that drops enable on wb_stall cannot overflow the FIFO, given the 4-cycle multiplier latency.
- wb_done asserts the cycle after the final pop empties the FIFO.
- Minimum pass length with out_ready tied high: N_COEF + 2 cycles from the first push to wb_done.

## Configuration
- POLY_WB_UNMASK_EN defined:
  - out_share1 = in_share1 ^ in_share2, registered at push; out_share2 = 0.
  - If the unmasked value is ≥ wb_q, err_range is set. The entry is still written.
- Undefined:
  - Shares pass through separately.
  - err_range is tied to 0.
  - No XOR logic is instantiated.

## Test plan
- Reset, then wb_start, then 256 in_valid pulses with out_ready = 1 and share1 = i ^ 0xACE123, share2 = 0xACE123 → out_addr runs 0..255 in order with matching shares; wb_done pulses exactly once; no err_* set.
- Backpressure: out_ready = 0 after wb_start; push 4 entries → wb_stall = 1 when occupancy reaches 4 (DEPTH = 8). Push 5 more with enable ignored → the 9th push sets err_overflow and in_idx = 9. Raise out_ready → the head at out_addr = 0 holds its shares stable until accepted.
- Full FIFO with push and pop in the same cycle → the push is accepted, occupancy stays 8, err_overflow stays 0.
- in_valid in IDLE, and a 257th in_valid in DRAIN → err_unexp = 1 in both cases; no extra entry is written; the next wb_start clears the flag.
- Assert poly_wb_rst after 100 pushes → next cycle all outputs are 0 and the FIFO is empty; a new pass starts again at out_addr = 0.
- POLY_WB_UNMASK_EN, wb_q = 8380417: share1 ^ share2 = 8380417 → err_range = 1. Value 8380416 → err_range stays 0 and out_share1 = 8380416.
